debug_step_controller: RTL and testbench
========================================

Name: debug_step_controller

Overview:
- Run-control block between the board buttons/switches (pwr, dbg, stp) and the ASIP pipeline.
- Produces the core clock-enable, so the core can be stopped, stepped N instructions, or halted on PC breakpoints.
- Sits in the AES_encryptor top, replacing the fixed single-step enable logic.
- Generalised in breakpoint count, step length, PC width and debounce time.

Parameters:
- N, 32, PC width.
- NBP, 4, number of PC breakpoint comparators (1..8).
- STEP_W, 8, width of the step-length and remaining-step counters.
- CNT_W, 32, width of the enabled-cycle counter.
- DB_CYCLES, 16, stable cycles required to accept a button level (>=1).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-low.
- pwr  input  1  power/start button, raw, active-low.
- dbg  input  1  debug mode switch, raw, 1 = debug.
- stp  input  1  step button, raw, active-low.
- step_len  input  STEP_W  instructions per step press; 0 treated as 1.
- pc  input  N  current fetch PC (PCF).
- retire  input  1  one instruction reached writeback this cycle.
- bp_en  input  NBP  per-breakpoint enable.
- bp_addr  input  NBP*N  breakpoint addresses, entry i at [i*N +: N].
- enable  output  1  core clock-enable.
- halted  output  1  state==HALT.
- run_state  output  2  00 IDLE, 01 RUN, 10 HALT, 11 STEP.
- bp_hit  output  1  sticky: last halt was caused by a breakpoint.
- bp_idx  output  3  index of the breakpoint that hit (lowest index wins).
- steps_left  output  STEP_W  remaining instructions in the current step.
- cycle_count  output  CNT_W  number of enabled cycles; saturates at all-ones.

Behaviour:
- Reset (rst=0 at posedge) applies regardless of state:
  - state IDLE;
  - enable, bp_hit, bp_idx, steps_left, cycle_count = 0;
  - synchronisers and debouncers cleared to the released level (pwr/stp = 1, dbg = 0).
- Inputs pwr, stp and dbg each pass through a 2-FF synchroniser, then a debouncer.
  - The debounced level changes only after DB_CYCLES consecutive equal synchronised samples.
  - pwr_press / stp_press are 1-cycle pulses on the debounced 1->0 edge.
  - dbg_q is the debounced dbg level.
  - Input-to-pulse latency is 2 + DB_CYCLES cycles.
- match = OR over i of (bp_en[i] && pc == bp_addr[i]). It is suppressed on the first enabled cycle after leaving HALT, so the core can resume from a breakpoint PC.
- enable is combinational:
  - (state==RUN && !match) || (state==STEP && !match).
  - It is 0 in IDLE and HALT.
- Transitions, evaluated in priority order each cycle:
  1. pwr_press: IDLE -> RUN if dbg_q=0, else HALT. Entering from IDLE clears cycle_count and bp_hit. Any other state -> IDLE.
  2. match in RUN or STEP -> HALT; bp_hit=1; bp_idx = lowest matching index.
  3. RUN with dbg_q=1 -> HALT. The halt takes effect after the current cycle; that cycle stays enabled.
  4. HALT with dbg_q=0 -> RUN; bp_hit cleared.
  5. HALT with stp_press -> STEP; steps_left = (step_len==0 ? 1 : step_len); bp_hit cleared.
  6. STEP: on each cycle with retire=1 && enable=1, decrement steps_left. When steps_left==1 and retire=1, go to HALT with steps_left=0.
  7. stp_press outside HALT is ignored.
- retire is sampled only while enable=1; a stalled core (no retire) keeps STEP active indefinitely.
- cycle_count increments on every cycle with enable=1 and holds at 2^CNT_W-1.
- step_len is sampled only on the stp_press that enters STEP; later changes do not affect the current step.

Test Plan:
- Reset: rst=0 for 2 cycles with all inputs toggling -> run_state=00, enable=0, cycle_count=0, bp_hit=0.
- Start: DB_CYCLES=2, dbg=0, pwr held low 5 cycles -> pwr_press 4 cycles after the falling edge; run_state=01 and enable=1 from the next cycle; cycle_count counts 1,2,3,...
- Step of 3: dbg=1, core in HALT, step_len=3, retire pulsed on alternate cycles -> enable stays high until the 3rd retire; steps_left goes 3,2,1,0; run_state=10 the cycle after.
- Step length 0: step_len=0, stp press -> exactly 1 instruction retires, then HALT.
- Breakpoint: bp_en=4'b0110, bp_addr[1]=bp_addr[2]=0x20, RUN until pc=0x20 -> enable=0 in that cycle; run_state=10; bp_hit=1; bp_idx=1. A step from there retires the instruction at 0x20 without re-halting.
- Priority: pwr_press and a match in the same RUN cycle -> run_state=00 (IDLE), bp_hit stays 0. pwr press again with dbg=1 -> HALT and cycle_count cleared.

Source files
------------

// File: rtl/debug_step_controller.sv
`default_nettype none
// ============================================================================
// debug_step_controller : run/halt/step control producing the core clock-enable
// Revision 1.0
// ============================================================================
module debug_step_controller #(
    parameter int N         = 32,
    parameter int NBP       = 4,
    parameter int STEP_W    = 8,
    parameter int CNT_W     = 32,
    parameter int DB_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwr,
    input  logic              dbg,
    input  logic              stp,
    input  logic [STEP_W-1:0] step_len,
    input  logic [N-1:0]      pc,
    input  logic              retire,
    input  logic [NBP-1:0]    bp_en,
    input  logic [NBP*N-1:0]  bp_addr,
    output logic              enable,
    output logic              halted,
    output logic [1:0]        run_state,
    output logic              bp_hit,
    output logic [2:0]        bp_idx,
    output logic [STEP_W-1:0] steps_left,
    output logic [CNT_W-1:0]  cycle_count
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10,
        STEP = 2'b11
    } state_t;

    localparam int        DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    // Released levels of {dbg, stp, pwr}
    localparam logic [2:0] REST = 3'b011;

    logic [2:0] raw;
    logic [2:0] db;
    logic [1:0] db_d;
    logic       pwr_press;
    logic       stp_press;
    logic       dbg_q;

    assign raw = {dbg, stp, pwr};

    generate
        for (genvar i = 0; i < 3; i++) begin : g_sync
            logic            s1;
            logic            s2;
            logic            lvl;
            logic [DB_W-1:0] cnt;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    s1  <= REST[i];
                    s2  <= REST[i];
                    lvl <= REST[i];
                    cnt <= '0;
                end else begin
                    s1 <= raw[i];
                    s2 <= s1;
                    if (s2 == lvl) begin
                        cnt <= '0;
                    end else if (cnt == DB_W'(DB_CYCLES - 1)) begin
                        lvl <= s2;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end

            assign db[i] = lvl;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            db_d <= REST[1:0];
        end else begin
            db_d <= db[1:0];
        end
    end

    assign pwr_press = db_d[0] & ~db[0];
    assign stp_press = db_d[1] & ~db[1];
    assign dbg_q     = db[2];

    state_t         state;
    logic           resume;
    logic [NBP-1:0] hits;
    logic [2:0]     hit_idx;
    logic           match;

    always_comb begin
        hit_idx = '0;
        for (int i = 0; i < NBP; i++) begin
            hits[i] = bp_en[i] && (pc == bp_addr[i*N +: N]);
        end
        for (int i = NBP - 1; i >= 0; i--) begin
            if (hits[i]) begin
                hit_idx = 3'(i);
            end
        end
    end

    // The first enabled cycle after a halt ignores breakpoints so the core can
    // step off the very PC it stopped on.
    assign match     = (|hits) && !resume;
    assign enable    = ((state == RUN) || (state == STEP)) && !match;
    assign halted    = (state == HALT);
    assign run_state = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            resume      <= 1'b0;
            bp_hit      <= 1'b0;
            bp_idx      <= '0;
            steps_left  <= '0;
            cycle_count <= '0;
        end else begin
            if ((state == RUN) || (state == STEP)) begin
                resume <= 1'b0;
            end

            if (pwr_press && (state == IDLE)) begin
                cycle_count <= '0;
            end else if (enable && (cycle_count != {CNT_W{1'b1}})) begin
                cycle_count <= cycle_count + 1'b1;
            end

            if (pwr_press) begin
                if (state == IDLE) begin
                    state  <= dbg_q ? HALT : RUN;
                    bp_hit <= 1'b0;
                end else begin
                    state <= IDLE;
                end
                resume <= 1'b0;
            end else if (((state == RUN) || (state == STEP)) && match) begin
                state  <= HALT;
                bp_hit <= 1'b1;
                bp_idx <= hit_idx;
            end else if ((state == RUN) && dbg_q) begin
                state <= HALT;
            end else if ((state == HALT) && !dbg_q) begin
                state  <= RUN;
                bp_hit <= 1'b0;
                resume <= 1'b1;
            end else if ((state == HALT) && stp_press) begin
                state      <= STEP;
                steps_left <= (step_len == '0) ? STEP_W'(1) : step_len;
                bp_hit     <= 1'b0;
                resume     <= 1'b1;
            end else if ((state == STEP) && retire && enable) begin
                if (steps_left == STEP_W'(1)) begin
                    state      <= HALT;
                    steps_left <= '0;
                end else begin
                    steps_left <= steps_left - 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_debug_step_controller.sv
`default_nettype none
// Scoreboard bench: stimulus queues timed expectations, a negedge monitor checks them.
module tb_debug_step_controller;

    localparam int N     = 32;
    localparam int NBP   = 4;
    localparam int SW    = 8;
    localparam int CW    = 6;
    localparam int DB    = 2;

    localparam int F_STATE = 0;
    localparam int F_EN    = 1;
    localparam int F_HIT   = 2;
    localparam int F_IDX   = 3;
    localparam int F_STEPS = 4;
    localparam int F_CNT   = 5;
    localparam int F_HALT  = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             pwr, dbg, stp, retire;
    logic [SW-1:0]    step_len;
    logic [N-1:0]     pc;
    logic [NBP-1:0]   bp_en;
    logic [NBP*N-1:0] bp_addr;
    logic             enable, halted, bp_hit;
    logic [1:0]       run_state;
    logic [2:0]       bp_idx;
    logic [SW-1:0]    steps_left;
    logic [CW-1:0]    cycle_count;

    debug_step_controller #(
        .N(N), .NBP(NBP), .STEP_W(SW), .CNT_W(CW), .DB_CYCLES(DB)
    ) dut (
        .clk(clk), .rst(rst), .pwr(pwr), .dbg(dbg), .stp(stp),
        .step_len(step_len), .pc(pc), .retire(retire),
        .bp_en(bp_en), .bp_addr(bp_addr),
        .enable(enable), .halted(halted), .run_state(run_state),
        .bp_hit(bp_hit), .bp_idx(bp_idx), .steps_left(steps_left),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          when;
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];

    task automatic expect_at(input int when, input string name, input int sel,
                             input logic [31:0] val);
        exp_t e;
        e.when = when;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        sbq.push_back(e);
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            F_STATE: return 32'(run_state);
            F_EN:    return 32'(enable);
            F_HIT:   return 32'(bp_hit);
            F_IDX:   return 32'(bp_idx);
            F_STEPS: return 32'(steps_left);
            F_CNT:   return 32'(cycle_count);
            F_HALT:  return 32'(halted);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].when == cyc) begin
                logic [31:0] act;
                act = observe(sbq[i].sel);
                total++;
                if (act !== sbq[i].val) begin
                    bad++;
                    $display("FAIL %s @cyc %0d: got %0h want %0h",
                             sbq[i].name, cyc, act, sbq[i].val);
                end
                sbq.delete(i);
            end else if (sbq[i].when < cyc) begin
                total++;
                bad++;
                $display("FAIL %s: never sampled (due cyc %0d, now %0d)",
                         sbq[i].name, sbq[i].when, cyc);
                sbq.delete(i);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int b;

    initial begin
        rst = 1'b0; pwr = 1'b0; stp = 1'b0; dbg = 1'b1; retire = 1'b1;
        step_len = 8'd5; pc = 32'h20; bp_en = 4'hF;
        bp_addr = {4{32'h20}};
        tick(1);
        pwr = 1'b1; stp = 1'b0; dbg = 1'b0; retire = 1'b0; pc = 32'h24;
        tick(1);
        rst = 1'b1; pwr = 1'b1; stp = 1'b1; dbg = 1'b0; retire = 1'b0;
        bp_en = '0; pc = 32'h10;
        expect_at(cyc, "rst_state", F_STATE, 0);
        expect_at(cyc, "rst_enable", F_EN, 0);
        expect_at(cyc, "rst_count", F_CNT, 0);
        expect_at(cyc, "rst_bphit", F_HIT, 0);
        expect_at(cyc, "rst_steps", F_STEPS, 0);
        tick(4);

        // Start in RUN, then let the counter saturate at 63
        b = cyc;
        pwr = 1'b0;
        expect_at(b + 4,  "start_idle", F_STATE, 0);
        expect_at(b + 5,  "start_run", F_STATE, 1);
        expect_at(b + 5,  "start_en", F_EN, 1);
        expect_at(b + 5,  "cnt0", F_CNT, 0);
        expect_at(b + 6,  "cnt1", F_CNT, 1);
        expect_at(b + 7,  "cnt2", F_CNT, 2);
        expect_at(b + 8,  "cnt3", F_CNT, 3);
        expect_at(b + 67, "cnt62", F_CNT, 62);
        expect_at(b + 68, "cnt_sat", F_CNT, 63);
        expect_at(b + 75, "cnt_hold", F_CNT, 63);
        tick(5);
        pwr = 1'b1;
        tick(71);

        // dbg=1 in RUN: last enabled cycle, then HALT
        b = cyc;
        dbg = 1'b1;
        expect_at(b + 4, "dbg_last_run", F_STATE, 1);
        expect_at(b + 4, "dbg_last_en", F_EN, 1);
        expect_at(b + 5, "dbg_halt", F_STATE, 2);
        expect_at(b + 5, "dbg_halt_en", F_EN, 0);
        expect_at(b + 5, "dbg_halted", F_HALT, 1);
        tick(13);

        // Step of 3 with retire on alternate cycles; step_len changed mid-step
        b = cyc;
        step_len = 8'd3;
        stp = 1'b0;
        expect_at(b + 4,  "step3_pre", F_STATE, 2);
        expect_at(b + 5,  "step3_state", F_STATE, 3);
        expect_at(b + 5,  "step3_s3", F_STEPS, 3);
        expect_at(b + 6,  "step3_s2", F_STEPS, 2);
        expect_at(b + 7,  "step3_s2b", F_STEPS, 2);
        expect_at(b + 8,  "step3_s1", F_STEPS, 1);
        expect_at(b + 9,  "step3_en", F_EN, 1);
        expect_at(b + 10, "step3_s0", F_STEPS, 0);
        expect_at(b + 10, "step3_halt", F_STATE, 2);
        expect_at(b + 10, "step3_en_off", F_EN, 0);
        tick(5);
        stp = 1'b1; retire = 1'b1;
        tick(1);
        retire = 1'b0; step_len = 8'd7;
        tick(1);
        retire = 1'b1;
        tick(1);
        retire = 1'b0;
        tick(1);
        retire = 1'b1;
        tick(1);
        retire = 1'b0;
        tick(4);

        // step_len 0 behaves as a single instruction
        b = cyc;
        step_len = 8'd0;
        stp = 1'b0;
        expect_at(b + 5, "len0_state", F_STATE, 3);
        expect_at(b + 5, "len0_steps", F_STEPS, 1);
        expect_at(b + 5, "len0_en", F_EN, 1);
        expect_at(b + 6, "len0_halt", F_STATE, 2);
        expect_at(b + 6, "len0_s0", F_STEPS, 0);
        tick(5);
        stp = 1'b1; retire = 1'b1;
        tick(1);
        retire = 1'b0;
        tick(8);

        // Breakpoint: entries 1 and 2 match, entry 0 matches but is disabled
        b = cyc;
        bp_en = 4'b0110;
        bp_addr = {32'h30, 32'h20, 32'h20, 32'h20};
        pc = 32'h10;
        dbg = 1'b0;
        expect_at(b + 5,  "bp_run", F_STATE, 1);
        expect_at(b + 5,  "bp_run_en", F_EN, 1);
        expect_at(b + 7,  "bp_en_off", F_EN, 0);
        expect_at(b + 8,  "bp_halt", F_STATE, 2);
        expect_at(b + 8,  "bp_hit", F_HIT, 1);
        expect_at(b + 8,  "bp_idx", F_IDX, 1);
        expect_at(b + 10, "bp_stay", F_STATE, 2);
        expect_at(b + 10, "bp_hit_stay", F_HIT, 1);
        tick(4);
        dbg = 1'b1;
        tick(3);
        pc = 32'h20;
        tick(6);

        // Step off the breakpoint PC
        b = cyc;
        step_len = 8'd1;
        stp = 1'b0;
        expect_at(b + 4, "resume_hit_kept", F_HIT, 1);
        expect_at(b + 5, "resume_state", F_STATE, 3);
        expect_at(b + 5, "resume_en", F_EN, 1);
        expect_at(b + 5, "resume_hit_clr", F_HIT, 0);
        expect_at(b + 6, "resume_halt", F_STATE, 2);
        expect_at(b + 6, "resume_nohit", F_HIT, 0);
        tick(5);
        stp = 1'b1; retire = 1'b1;
        tick(1);
        retire = 1'b0;
        tick(6);

        // pwr_press beats a breakpoint in the same RUN cycle
        b = cyc;
        pc = 32'h10;
        dbg = 1'b0;
        expect_at(b + 5,  "prio_run", F_STATE, 1);
        expect_at(b + 9,  "prio_run2", F_STATE, 1);
        expect_at(b + 9,  "prio_en_off", F_EN, 0);
        expect_at(b + 10, "prio_idle", F_STATE, 0);
        expect_at(b + 10, "prio_hit0", F_HIT, 0);
        expect_at(b + 10, "prio_nothalt", F_HALT, 0);
        tick(5);
        pwr = 1'b0;
        tick(4);
        pc = 32'h20;
        tick(1);
        pwr = 1'b1; pc = 32'h10; dbg = 1'b1;
        tick(10);

        // IDLE -> HALT with dbg=1 clears the counter, then RUN counts again;
        // a step press while running is ignored
        b = cyc;
        pwr = 1'b0;
        expect_at(b + 4,  "re_idle", F_STATE, 0);
        expect_at(b + 4,  "re_cnt_kept", F_CNT, 63);
        expect_at(b + 5,  "re_halt", F_STATE, 2);
        expect_at(b + 5,  "re_halted", F_HALT, 1);
        expect_at(b + 5,  "re_cnt_clr", F_CNT, 0);
        expect_at(b + 11, "re_run", F_STATE, 1);
        expect_at(b + 11, "re_cnt0", F_CNT, 0);
        expect_at(b + 13, "re_cnt2", F_CNT, 2);
        expect_at(b + 19, "stp_ignored", F_STATE, 1);
        expect_at(b + 19, "re_cnt8", F_CNT, 8);
        tick(5);
        pwr = 1'b1;
        tick(1);
        dbg = 1'b0;
        tick(7);
        stp = 1'b0;
        tick(5);
        stp = 1'b1;
        tick(5);

        if (sbq.size() != 0) begin
            total += sbq.size();
            bad   += sbq.size();
            $display("FAIL scoreboard_drain: left %0d want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
